// File: rtl/legv8_pkg.sv
// ----------------------------------------------------------------------------
// legv8_pkg
// Shared definitions for the LEGv8 multi-cycle control unit:
//   - controller state encoding (FETCH..FAULT)
//   - instruction-class encoding produced by the opcode decoder
//   - opcode match/mask constants and the classifier pattern table
//   - alu_op / alu_src encodings driven towards the datapath
// ----------------------------------------------------------------------------
package legv8_pkg;

    // Controller states. The numeric values are visible on state_o for debug.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    // Instruction classes. ILLEGAL is zero so a cleared class register
    // never looks like a real instruction.
    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_B       = 4'd1,
        CLS_CBZ     = 4'd2,
        CLS_CBNZ    = 4'd3,
        CLS_LDUR    = 4'd4,
        CLS_STUR    = 4'd5,
        CLS_RTYPE   = 4'd6,
        CLS_ADDI    = 4'd7,
        CLS_SUBI    = 4'd8
    } iclass_e;

    // Width of the architectural opcode field (instruction bits [31:21]).
    localparam int OP_BITS = 11;

    // Opcode match values; don't-care bits are zero here and masked off below.
    localparam logic [OP_BITS-1:0] OP_B    = 11'b000101_00000;
    localparam logic [OP_BITS-1:0] OP_CBZ  = 11'b10110100_000;
    localparam logic [OP_BITS-1:0] OP_CBNZ = 11'b10110101_000;
    localparam logic [OP_BITS-1:0] OP_LDUR = 11'b11111000010;
    localparam logic [OP_BITS-1:0] OP_STUR = 11'b11111000000;
    localparam logic [OP_BITS-1:0] OP_ADD  = 11'b10001011000;
    localparam logic [OP_BITS-1:0] OP_SUB  = 11'b11001011000;
    localparam logic [OP_BITS-1:0] OP_AND  = 11'b10001010000;
    localparam logic [OP_BITS-1:0] OP_ORR  = 11'b10101010000;
    localparam logic [OP_BITS-1:0] OP_ADDI = 11'b1001000100_0;
    localparam logic [OP_BITS-1:0] OP_SUBI = 11'b1101000100_0;

    // Masks: B decodes on [10:5], CB on [10:3], immediates on [10:1].
    localparam logic [OP_BITS-1:0] MASK_B   = 11'b111111_00000;
    localparam logic [OP_BITS-1:0] MASK_CB  = 11'b11111111_000;
    localparam logic [OP_BITS-1:0] MASK_IMM = 11'b1111111111_0;
    localparam logic [OP_BITS-1:0] MASK_ALL = 11'b11111111111;

    // Classifier pattern table. The patterns are mutually exclusive, so the
    // order only matters for readability.
    localparam int NUM_PATTERNS = 11;

    localparam logic [OP_BITS-1:0] PAT_MATCH [NUM_PATTERNS] = '{
        OP_B, OP_CBZ, OP_CBNZ, OP_LDUR, OP_STUR,
        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI
    };

    localparam logic [OP_BITS-1:0] PAT_MASK [NUM_PATTERNS] = '{
        MASK_B, MASK_CB, MASK_CB, MASK_ALL, MASK_ALL,
        MASK_ALL, MASK_ALL, MASK_ALL, MASK_ALL, MASK_IMM, MASK_IMM
    };

    localparam iclass_e PAT_CLASS [NUM_PATTERNS] = '{
        CLS_B, CLS_CBZ, CLS_CBNZ, CLS_LDUR, CLS_STUR,
        CLS_RTYPE, CLS_RTYPE, CLS_RTYPE, CLS_RTYPE, CLS_ADDI, CLS_SUBI
    };

    // alu_op encodings
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_PASSB = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_IMM   = 2'b11;

    // alu_src encodings
    localparam logic [1:0] ALU_SRC_REG = 2'd0;
    localparam logic [1:0] ALU_SRC_DT  = 2'd1;
    localparam logic [1:0] ALU_SRC_IMM = 2'd2;

    // States that own the shared memory port and wait for mem_ready.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/legv8_opcode_decoder.sv
// ----------------------------------------------------------------------------
// legv8_opcode_decoder
// Purely combinational opcode-to-class classifier. Shared by the multi-cycle
// controller and the ALU-control block.
//
// Parameters
//   OPCODE_W   : opcode field width (the low 11 bits are decoded)
//   ENABLE_IMM : 1 = ADDI/SUBI decode normally, 0 = they classify as ILLEGAL
// Ports
//   i_opcode   in  OPCODE_W  opcode field from the instruction register
//   o_class    out iclass_e  decoded instruction class
// ----------------------------------------------------------------------------
module legv8_opcode_decoder
    import legv8_pkg::*;
#(
    parameter int OPCODE_W   = 11,
    parameter bit ENABLE_IMM = 1'b1
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output iclass_e             o_class
);

    logic [OP_BITS-1:0]      w_op;
    logic [NUM_PATTERNS-1:0] w_hit;

    assign w_op = i_opcode[OP_BITS-1:0];

    // One masked comparator per table entry. Immediate patterns are
    // compiled out entirely when immediates are disabled.
    generate
        for (genvar gi = 0; gi < NUM_PATTERNS; gi++) begin : g_pat
            if (!ENABLE_IMM &&
                ((PAT_CLASS[gi] == CLS_ADDI) || (PAT_CLASS[gi] == CLS_SUBI))) begin : g_off
                assign w_hit[gi] = 1'b0;
            end else begin : g_on
                assign w_hit[gi] = ((w_op & PAT_MASK[gi]) == PAT_MATCH[gi]);
            end
        end
    endgenerate

    // At most one pattern can hit; no hit means ILLEGAL.
    always_comb begin
        o_class = CLS_ILLEGAL;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            if (w_hit[i]) begin
                o_class = PAT_CLASS[i];
            end
        end
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// legv8_multicycle_ctrl
// Registered multi-cycle control FSM for the LEGv8 datapath
// (FETCH -> DECODE -> EXEC -> [MEM] -> [WB]) with a shared instruction/data
// memory port, a bounded mem_ready wait and a sticky FAULT state.
//
// Parameters
//   OPCODE_W    : opcode field width
//   MEM_TIMEOUT : max consecutive not-ready cycles in FETCH/MEM (0 = no limit)
//   ENABLE_IMM  : decode ADDI/SUBI (0 makes them illegal)
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   opcode      in   instruction-register opcode, valid from DECODE onward
//   zero        in   ALU zero flag, used in EXEC for CBZ/CBNZ
//   mem_ready   in   memory completes the current access this cycle
//   iord        out  0 = PC addresses memory, 1 = ALU result
//   ir_write    out  load the instruction register
//   pc_write    out  update the PC
//   pc_src      out  0 = PC+4, 1 = branch target
//   reg2loc     out  second read register from Rt (1) or Rm (0)
//   alu_src[2]  out  register / DT address / immediate
//   alu_op[2]   out  add / pass-B / R-type funct / immediate
//   mem_read    out  memory read strobe
//   mem_write   out  memory write strobe
//   mem_to_reg  out  writeback from memory
//   reg_write   out  register file write enable
//   fault       out  sticky illegal-opcode or timeout flag
//   state_o[3]  out  current state, debug only
// ----------------------------------------------------------------------------
module legv8_multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int OPCODE_W    = 11,
    parameter int MEM_TIMEOUT = 15,
    parameter bit ENABLE_IMM  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg2loc,
    output logic [1:0]          alu_src,
    output logic [1:0]          alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                fault,
    output logic [2:0]          state_o
);

    localparam int                WAIT_W     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam bit                TIMEOUT_ON = (MEM_TIMEOUT != 0);

    state_e            r_state;
    state_e            w_state_next;
    iclass_e           r_class;
    iclass_e           w_class_next;
    iclass_e           w_dec_class;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_next;
    logic              r_fault;
    logic              w_in_wait;
    logic              w_timeout;

    legv8_opcode_decoder #(
        .OPCODE_W   (OPCODE_W),
        .ENABLE_IMM (ENABLE_IMM)
    ) u_decoder (
        .i_opcode (opcode),
        .o_class  (w_dec_class)
    );

    assign w_in_wait = is_wait_state(r_state);

    // The limit only trips while memory is still not ready; a mem_ready on
    // the limit cycle completes the access normally.
    assign w_timeout = TIMEOUT_ON && w_in_wait && !mem_ready && (r_wait == WAIT_LIMIT);

    // ------------------------------------------------------------------
    // Next-state, class latch and wait counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_class_next = r_class;

        case (r_state)
            ST_FETCH: begin
                if (mem_ready) begin
                    w_state_next = ST_DECODE;
                end else if (w_timeout) begin
                    w_state_next = ST_FAULT;
                end
            end

            ST_DECODE: begin
                // The class is captured once here and held through the
                // rest of the instruction, so opcode may change afterwards.
                w_class_next = w_dec_class;
                w_state_next = (w_dec_class == CLS_ILLEGAL) ? ST_FAULT : ST_EXEC;
            end

            ST_EXEC: begin
                case (r_class)
                    CLS_RTYPE, CLS_ADDI, CLS_SUBI: w_state_next = ST_WB;
                    CLS_LDUR, CLS_STUR:            w_state_next = ST_MEM;
                    CLS_B, CLS_CBZ, CLS_CBNZ:      w_state_next = ST_FETCH;
                    default:                       w_state_next = ST_FAULT;
                endcase
            end

            ST_MEM: begin
                if (mem_ready) begin
                    w_state_next = (r_class == CLS_LDUR) ? ST_WB : ST_FETCH;
                end else if (w_timeout) begin
                    w_state_next = ST_FAULT;
                end
            end

            ST_WB:    w_state_next = ST_FETCH;
            ST_FAULT: w_state_next = ST_FAULT;
            default:  w_state_next = ST_FAULT;
        endcase
    end

    // The counter is zero whenever we are not mid-wait, which also makes it
    // zero on every entry into FETCH or MEM.
    always_comb begin
        w_wait_next = '0;
        if (TIMEOUT_ON && w_in_wait && !mem_ready && !w_timeout) begin
            w_wait_next = r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_class <= CLS_ILLEGAL;
            r_wait  <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_class <= w_class_next;
            r_wait  <= w_wait_next;
            r_fault <= r_fault | (w_state_next == ST_FAULT);
        end
    end

    // ------------------------------------------------------------------
    // Datapath controls: decoded from the registered state and class, plus
    // mem_ready (FETCH completion) and zero (conditional branches).
    // ------------------------------------------------------------------
    always_comb begin
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = ALU_SRC_REG;
        alu_op     = ALU_OP_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;

        case (r_state)
            ST_FETCH: begin
                // Read strobe stays up, unchanged, until the access completes.
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end

            ST_EXEC: begin
                case (r_class)
                    CLS_RTYPE: begin
                        alu_op  = ALU_OP_RTYPE;
                        alu_src = ALU_SRC_REG;
                        reg2loc = 1'b0;
                    end
                    CLS_ADDI, CLS_SUBI: begin
                        alu_op  = ALU_OP_IMM;
                        alu_src = ALU_SRC_IMM;
                    end
                    CLS_LDUR, CLS_STUR: begin
                        alu_op  = ALU_OP_ADD;
                        alu_src = ALU_SRC_DT;
                        reg2loc = 1'b1;
                    end
                    CLS_CBZ: begin
                        alu_op   = ALU_OP_PASSB;
                        reg2loc  = 1'b1;
                        pc_src   = 1'b1;
                        pc_write = zero;
                    end
                    CLS_CBNZ: begin
                        alu_op   = ALU_OP_PASSB;
                        reg2loc  = 1'b1;
                        pc_src   = 1'b1;
                        pc_write = !zero;
                    end
                    CLS_B: begin
                        pc_src   = 1'b1;
                        pc_write = 1'b1;
                    end
                    default: ;
                endcase
            end

            ST_MEM: begin
                iord      = 1'b1;
                mem_read  = (r_class == CLS_LDUR);
                mem_write = (r_class == CLS_STUR);
            end

            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (r_class == CLS_LDUR);
            end

            default: ;
        endcase

        // Reset abandons any access in flight: every strobe drops with
        // rst_n, not at the next clock edge.
        if (!rst_n) begin
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            reg2loc    = 1'b0;
            alu_src    = ALU_SRC_REG;
            alu_op     = ALU_OP_ADD;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
        end
    end

    assign fault   = r_fault;
    assign state_o = r_state;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_legv8_multicycle_ctrl
// Two controllers share one stimulus stream:
//   dut_a : MEM_TIMEOUT=15, ENABLE_IMM=1 (never times out with the waits used)
//   dut_b : MEM_TIMEOUT=3,  ENABLE_IMM=0 (timeouts and illegal ADDI/SUBI)
// Each instruction is expanded into a list of expected cycles (phase, memory
// readiness, wait index) from its class; the outputs of both controllers are
// compared against that expectation every cycle.
// ----------------------------------------------------------------------------
module tb_legv8_multicycle_ctrl;

    localparam int TO_B = 3;

    // Phase numbers follow the documented state_o encoding.
    localparam int P_F   = 0;
    localparam int P_D   = 1;
    localparam int P_X   = 2;
    localparam int P_M   = 3;
    localparam int P_W   = 4;
    localparam int P_FLT = 5;

    typedef enum int {K_B, K_CBZ, K_CBNZ, K_LDUR, K_STUR, K_R, K_ADDI, K_SUBI, K_ILL} kind_t;

    typedef struct {
        int ph;
        bit rdy;
        int idx;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic       a_iord, a_ir_write, a_pc_write, a_pc_src, a_reg2loc;
    logic [1:0] a_alu_src, a_alu_op;
    logic       a_mem_read, a_mem_write, a_mem_to_reg, a_reg_write, a_fault;
    logic [2:0] a_state;

    logic       b_iord, b_ir_write, b_pc_write, b_pc_src, b_reg2loc;
    logic [1:0] b_alu_src, b_alu_op;
    logic       b_mem_read, b_mem_write, b_mem_to_reg, b_reg_write, b_fault;
    logic [2:0] b_state;

    int n_err = 0;
    int n_chk = 0;
    int n_instr = 0;

    logic [10:0] ill_ops [6] = '{11'b00000000000, 11'b11111111111, 11'b11111000011,
                                 11'b10001011001, 11'b10110110000, 11'b10010001010};

    always #5 clk = ~clk;

    legv8_multicycle_ctrl #(
        .OPCODE_W    (11),
        .MEM_TIMEOUT (15),
        .ENABLE_IMM  (1'b1)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (a_iord),
        .ir_write   (a_ir_write),
        .pc_write   (a_pc_write),
        .pc_src     (a_pc_src),
        .reg2loc    (a_reg2loc),
        .alu_src    (a_alu_src),
        .alu_op     (a_alu_op),
        .mem_read   (a_mem_read),
        .mem_write  (a_mem_write),
        .mem_to_reg (a_mem_to_reg),
        .reg_write  (a_reg_write),
        .fault      (a_fault),
        .state_o    (a_state)
    );

    legv8_multicycle_ctrl #(
        .OPCODE_W    (11),
        .MEM_TIMEOUT (TO_B),
        .ENABLE_IMM  (1'b0)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (b_iord),
        .ir_write   (b_ir_write),
        .pc_write   (b_pc_write),
        .pc_src     (b_pc_src),
        .reg2loc    (b_reg2loc),
        .alu_src    (b_alu_src),
        .alu_op     (b_alu_op),
        .mem_read   (b_mem_read),
        .mem_write  (b_mem_write),
        .mem_to_reg (b_mem_to_reg),
        .reg_write  (b_reg_write),
        .fault      (b_fault),
        .state_o    (b_state)
    );

    // {state, fault, iord, ir_write, pc_write, pc_src, reg2loc,
    //  alu_src, alu_op, mem_read, mem_write, mem_to_reg, reg_write}
    wire [16:0] obs_a = {a_state, a_fault, a_iord, a_ir_write, a_pc_write, a_pc_src, a_reg2loc,
                         a_alu_src, a_alu_op, a_mem_read, a_mem_write, a_mem_to_reg, a_reg_write};
    wire [16:0] obs_b = {b_state, b_fault, b_iord, b_ir_write, b_pc_write, b_pc_src, b_reg2loc,
                         b_alu_src, b_alu_op, b_mem_read, b_mem_write, b_mem_to_reg, b_reg_write};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected control vector for one cycle of a phase, straight from the
    // per-state control table.
    function automatic logic [16:0] exp_vec(input int ph, input kind_t k, input logic rdy, input logic z);
        logic [2:0] st;
        logic       flt, iord_e, irw, pcw, pcs, r2l, mrd, mwr, m2r, rw;
        logic [1:0] asrc, aop;
        st = 3'(ph);
        {flt, iord_e, irw, pcw, pcs, r2l, mrd, mwr, m2r, rw} = '0;
        asrc = 2'd0;
        aop  = 2'b00;
        case (ph)
            P_F: begin
                mrd = 1'b1;
                irw = rdy;
                pcw = rdy;
            end
            P_X: begin
                case (k)
                    K_R:            aop = 2'b10;
                    K_ADDI, K_SUBI: begin aop = 2'b11; asrc = 2'd2; end
                    K_LDUR, K_STUR: begin asrc = 2'd1; r2l = 1'b1; end
                    K_CBZ:          begin aop = 2'b01; r2l = 1'b1; pcs = 1'b1; pcw = z;  end
                    K_CBNZ:         begin aop = 2'b01; r2l = 1'b1; pcs = 1'b1; pcw = !z; end
                    K_B:            begin pcs = 1'b1; pcw = 1'b1; end
                    default: ;
                endcase
            end
            P_M: begin
                iord_e = 1'b1;
                mrd    = (k == K_LDUR);
                mwr    = (k == K_STUR);
            end
            P_W: begin
                rw  = 1'b1;
                m2r = (k == K_LDUR);
            end
            P_FLT: flt = 1'b1;
            default: ;
        endcase
        return {st, flt, iord_e, irw, pcw, pcs, r2l, asrc, aop, mrd, mwr, m2r, rw};
    endfunction

    function automatic logic [10:0] make_op(input kind_t k);
        logic [10:0] r;
        r = 11'($urandom);
        case (k)
            K_B:    return {6'b000101, r[4:0]};
            K_CBZ:  return {8'b10110100, r[2:0]};
            K_CBNZ: return {8'b10110101, r[2:0]};
            K_LDUR: return 11'b11111000010;
            K_STUR: return 11'b11111000000;
            K_R: begin
                case (r[1:0])
                    2'd0:    return 11'b10001011000;
                    2'd1:    return 11'b11001011000;
                    2'd2:    return 11'b10001010000;
                    default: return 11'b10101010000;
                endcase
            end
            K_ADDI: return {10'b1001000100, r[0]};
            K_SUBI: return {10'b1101000100, r[0]};
            default: return ill_ops[$urandom_range(0, 5)];
        endcase
    endfunction

    // Called just after a rising edge; returns just after a rising edge.
    task automatic apply_reset();
        rst_n     = 1'b0;
        mem_ready = 1'($urandom);
        #1;
        check_eq("reset.A", 32'(obs_a), 32'd0);
        check_eq("reset.B", 32'(obs_b), 32'd0);
        @(posedge clk);
        #1;
        check_eq("reset_hold.A", 32'(obs_a), 32'd0);
        rst_n = 1'b1;
    endtask

    // Run one instruction. fw/mw = not-ready cycles in FETCH/MEM,
    // zmode 0/1 = fixed zero flag, 2 = random, abort_at = cycle index at
    // which reset is asserted mid-instruction (-1 = never).
    task automatic do_instr(input kind_t k, input logic [10:0] op, input int fw, input int mw,
                            input int zmode, input int abort_at);
        item_t      items[$];
        item_t      it;
        bit         b_dead;
        logic [16:0] ea, eb;
        string      tag;
        b_dead = 1'b0;
        for (int i = 0; i < fw; i++) items.push_back('{P_F, 1'b0, i});
        items.push_back('{P_F, 1'b1, fw});
        items.push_back('{P_D, 1'b0, 0});
        if (k == K_ILL) begin
            for (int i = 0; i < 3; i++) items.push_back('{P_FLT, 1'b0, i});
        end else begin
            items.push_back('{P_X, 1'b0, 0});
            if (k == K_LDUR || k == K_STUR) begin
                for (int i = 0; i < mw; i++) items.push_back('{P_M, 1'b0, i});
                items.push_back('{P_M, 1'b1, mw});
            end
            if (k == K_LDUR || k == K_R || k == K_ADDI || k == K_SUBI)
                items.push_back('{P_W, 1'b0, 0});
        end

        n_instr++;
        $display("instr %0d kind=%s op=%b fw=%0d mw=%0d cycles=%0d", n_instr, k.name(), op, fw, mw,
                 (abort_at >= 0) ? abort_at : items.size());

        for (int n = 0; n < items.size(); n++) begin
            it        = items[n];
            mem_ready = (it.ph == P_F || it.ph == P_M) ? it.rdy : 1'($urandom);
            zero      = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            opcode    = (it.ph == P_D) ? op : 11'($urandom);
            ea = exp_vec(it.ph, k, mem_ready, zero);
            eb = b_dead ? exp_vec(P_FLT, k, 1'b0, 1'b0) : ea;

            if (n == abort_at) begin
                #2;
                check_eq("abort_pre.mem_write", 32'(a_mem_write), 32'(ea[2]));
                rst_n = 1'b0;
                #1;
                check_eq("abort.mem_write", 32'(a_mem_write), 32'd0);
                check_eq("abort.A", 32'(obs_a), 32'd0);
                check_eq("abort.B", 32'(obs_b), 32'd0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end

            @(negedge clk);
            tag = $sformatf("%s.c%0d.ph%0d", k.name(), n, it.ph);
            check_eq({"A.", tag}, 32'(obs_a), 32'(ea));
            check_eq({"B.", tag}, 32'(obs_b), 32'(eb));
            if (!b_dead && (it.ph == P_F || it.ph == P_M) && !it.rdy && it.idx == TO_B) b_dead = 1'b1;
            if (!b_dead && it.ph == P_D && (k == K_ILL || k == K_ADDI || k == K_SUBI)) b_dead = 1'b1;
            @(posedge clk);
            #1;
        end

        if (b_dead) apply_reset();
    endtask

    initial begin
        kind_t k;
        int    fw, mw;

        apply_reset();

        // Directed cases
        do_instr(K_R,    11'b10001011000, 0, 0, 2, -1);  // ADD, memory always ready
        do_instr(K_LDUR, 11'b11111000010, 0, 2, 2, -1);  // LDUR with 2 MEM waits
        do_instr(K_CBZ,  11'b10110100000, 0, 0, 1, -1);  // taken
        do_instr(K_CBZ,  11'b10110100101, 0, 0, 0, -1);  // not taken
        do_instr(K_CBNZ, 11'b10110101000, 0, 0, 1, -1);  // not taken
        do_instr(K_CBNZ, 11'b10110101011, 0, 0, 0, -1);  // taken
        do_instr(K_B,    11'b00010111111, 1, 0, 2, -1);
        do_instr(K_ADDI, 11'b10010001000, 0, 0, 2, -1);  // legal on A, illegal on B
        do_instr(K_SUBI, 11'b11010001001, 0, 0, 2, -1);
        do_instr(K_R,    11'b11001011000, 4, 0, 2, -1);  // B times out in FETCH
        do_instr(K_R,    11'b10101010000, 3, 0, 2, -1);  // ready on the limit cycle
        do_instr(K_STUR, 11'b11111000000, 0, 3, 2, -1);  // ready on the limit cycle in MEM
        do_instr(K_LDUR, 11'b11111000010, 0, 5, 2, -1);  // B times out in MEM
        do_instr(K_ILL,  11'b11111111111, 0, 0, 2, -1);
        do_instr(K_STUR, 11'b11111000000, 0, 3, 2, 4);   // reset mid-MEM
        do_instr(K_R,    11'b10001010000, 0, 0, 2, -1);  // first instruction after reset

        // Randomised instruction stream
        for (int t = 0; t < 300; t++) begin
            k  = kind_t'($urandom_range(0, 8));
            fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            do_instr(k, make_op(k), fw, mw, 2, -1);
            if (k == K_ILL) apply_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "time limit");
    end

endmodule
